func_dc_pipe: RTL and testbench
===============================

Name: func_dc_pipe

Overview:
Parametrised, pipelined evaluator of an N-input Boolean function given as a truth-table parameter. The function is realised as a decoder tree with one register stage per 2-bit decoder level. A one-hot minterm vector is expanded level by level and ANDed with the truth table.
Besides single-vector evaluation with a valid/ready handshake, the block has a self-test sweep mode. The sweep enumerates all 2^N input vectors, counts the minterms where f=1, and signals done. It is the general replacement for the fixed 5-input decoder-based function units in the lab designs.

Parameters:
N, 5, number of function inputs (2..8)
TRUTH, 32'hF0F0_0FF0, 2^N-bit truth table; bit i = f(x==i)
L (localparam), (N+1)/2, decoder levels; the last level is a 1-bit decoder when N is odd

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  x is valid this cycle
in_ready  out  1  block accepts x (combinational, = ~busy)
x  in  N  input vector; x[N-1] is MSB and is decoded at level 1
start  in  1  one-cycle pulse, begin sweep
busy  out  1  sweep issuing or draining
out_valid  out  1  one-cycle pulse, f_out valid
f_out  out  1  function value for the vector accepted L+1 cycles earlier
ones_count  out  N+1  number of minterms with f=1 found by the last sweep
done  out  1  one-cycle pulse when the final sweep result leaves the pipe

Behaviour:
- Reset values:
  - in_ready=0 during the reset cycle, 1 afterwards.
  - busy=0, out_valid=0, f_out=0, ones_count=0, done=0.
  - All pipeline valid/tag bits are cleared; FSM goes to IDLE.
- Accept rule:
  - An external vector is accepted on a rising edge with in_valid & in_ready.
  - There is no output backpressure; one vector per cycle is sustained.
- Pipeline structure:
  - Stage k (1..L) registers three things:
    - the one-hot vector of width 4^k (2^N at the final stage), expanded from stage k-1 by decoding the next 2 MSBs of x;
    - the undecoded remaining bits of x;
    - a valid bit and a sweep-tag bit.
  - Output stage registers f_out = |(onehot & TRUTH).
- Latency: exactly L+1 cycles from acceptance to out_valid (N=5: 4 cycles). Order is preserved.
- f_out holds its last value while out_valid=0.
- FSM states:
  - IDLE: in_ready=1. start → SWEEP; ones_count is cleared and the internal counter cnt is set to 0.
  - SWEEP: each cycle injects cnt (tag=1) into stage 1 and increments cnt. After injecting 2^N-1 → DRAIN. in_ready=0, busy=1.
  - DRAIN: wait until the last tagged vector exits. On that exit cycle, pulse done=1 with out_valid=1 and go to IDLE. busy=1.
- Counting:
  - ones_count increments on each out_valid with tag=1 and f_out=1.
  - The final increment is visible in the same cycle as done.
  - ones_count holds until the next start or rst.
  - Width N+1, so an all-ones table gives 2^N without wrap.
- Simultaneous start & in_valid in IDLE:
  - Both are accepted.
  - The external vector enters the pipe first (untagged, not counted); sweep vectors follow from the next cycle.
- start while busy: ignored.
- in_valid while busy: not accepted (in_ready=0); no state change.
- External vectors in flight when a sweep starts complete normally and are never counted.
- Mid-sweep results: out_valid pulses for every swept vector, with f_out meaningful.
- rst at any time (including mid-sweep):
  - All in-flight results are discarded.
  - No out_valid or done is generated afterwards for them.
  - ones_count=0.
- Sweep duration: start accepted at cycle 0 → done at cycle 2^N+L+1 (N=5: cycle 36).

Test Plan:
- Reset: assert rst 2 cycles mid-operation → all outputs 0 next cycle, in_ready=1 after release, no stray out_valid.
- Single eval, N=5, TRUTH=32'hF0F0_0FF0:
  - x=5'd4 accepted at cycle 0 → out_valid=1, f_out=1 at cycle 4.
  - x=5'd0 → f_out=0.
  - x=5'd31 → f_out=1.
- Streaming: x=0..31 back-to-back with in_valid=1 → 32 consecutive out_valid pulses, f_out sequence equals TRUTH bits 0..31.
- Sweep: start pulse → busy=1, in_ready=0, done at cycle 36, ones_count=16; TRUTH=0 gives 0, TRUTH=32'hFFFF_FFFF gives 32.
- Collisions:
  - start with in_valid (x=5'd4) in the same cycle → that result appears at cycle 4, untagged; ones_count still 16.
  - start during busy → no restart.
  - in_valid during busy → ignored.
- Reset mid-sweep at cycle 20 → no done, ones_count=0. A new start afterwards completes normally with 16.

Source files
------------

// File: rtl/func_dc_pipe.sv
// func_dc_pipe: pipelined decoder-tree evaluator of an N-input truth table.
// Ports: clk/rst; in_valid,in_ready,x -> out_valid,f_out; start,busy,done,ones_count sweep.
module func_dc_pipe #(
  parameter int N = 5,
  parameter logic [(1<<N)-1:0] TRUTH = 32'hF0F0_0FF0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic         start,
  output logic         busy,
  output logic         out_valid,
  output logic         f_out,
  output logic [N:0]   ones_count,
  output logic         done
);

  localparam int L = (N + 1) / 2;
  localparam int M = 1 << N;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic           inject;
  logic           src_vld;
  logic [N-1:0]   src_x;
  logic [M-1:0]   oh_l;
  logic           vld_l, tag_l;
  logic           f_nx;
  logic           last;

  assign busy     = (state_q != IDLE);
  assign in_ready = ~busy & ~rst;
  assign src_vld  = (in_valid & in_ready) | inject;
  assign src_x    = inject ? cnt_q : x;

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int PB = 2 * k - 2;
    localparam int CB = (2 * k > N) ? N : 2 * k;
    localparam int B  = CB - PB;

    logic [(1<<PB)-1:0] oh_in;
    logic [N-PB-1:0]    rem_in;
    logic               vld_in, tag_in;
    logic [B-1:0]       sel;
    logic [(1<<CB)-1:0] oh_nx, oh;
    logic               vld, tag;

    if (k == 1) begin : g_src
      assign oh_in  = 1'b1;
      assign rem_in = src_x;
      assign vld_in = src_vld;
      assign tag_in = inject;
    end else begin : g_src
      assign oh_in  = g_lvl[k-1].oh;
      assign rem_in = g_lvl[k-1].g_r.rem;
      assign vld_in = g_lvl[k-1].vld;
      assign tag_in = g_lvl[k-1].tag;
    end

    assign sel = rem_in[N-PB-1 -: B];

    // Each parent minterm fans out to 2^B children selected by the next MSBs.
    always_comb begin
      oh_nx = '0;
      for (int j = 0; j < (1 << CB); j++) begin
        oh_nx[j] = oh_in[j >> B] & (sel == B'(j));
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        oh  <= '0;
        vld <= 1'b0;
        tag <= 1'b0;
      end else begin
        oh  <= oh_nx;
        vld <= vld_in;
        tag <= tag_in;
      end
    end

    if (k < L) begin : g_r
      logic [N-CB-1:0] rem;
      always_ff @(posedge clk) begin
        if (rst) rem <= '0;
        else     rem <= rem_in[N-CB-1:0];
      end
    end
  end

  assign oh_l  = g_lvl[L].oh;
  assign vld_l = g_lvl[L].vld;
  assign tag_l = g_lvl[L].tag;
  assign f_nx  = |(oh_l & TRUTH);

  // Sweep vectors leave in ascending order, so the all-ones minterm is the last.
  assign last = (state_q == DRAIN) & vld_l & tag_l & oh_l[M-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inject  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        inject = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = DRAIN;
      end
      DRAIN: begin
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      f_out      <= 1'b0;
      done       <= 1'b0;
      ones_count <= '0;
    end else begin
      out_valid <= vld_l;
      done      <= last;
      if (vld_l) f_out <= f_nx;
      if (state_q == IDLE && start)
        ones_count <= '0;
      else if (vld_l && tag_l && f_nx)
        ones_count <= ones_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_func_dc_pipe.sv
// tb_func_dc_pipe: randomized self-checking bench for func_dc_pipe.
// Three instances share stimulus: main table, all-zero table, all-one table.
module tb_func_dc_pipe;

  localparam int N = 5;
  localparam int L = (N + 1) / 2;
  localparam int M = 1 << N;
  localparam logic [M-1:0] T_MAIN = 32'hF0F0_0FF0;
  localparam logic [M-1:0] T_ZERO = '0;
  localparam logic [M-1:0] T_ONES = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic start = 1'b0;
  logic [N-1:0] x = '0;

  logic in_ready, busy, out_valid, f_out, done;
  logic [N:0] ones_count;
  logic in_ready_z, busy_z, out_valid_z, f_out_z, done_z;
  logic [N:0] ones_count_z;
  logic in_ready_f, busy_f, out_valid_f, f_out_f, done_f;
  logic [N:0] ones_count_f;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [M-1:0] tt;

  func_dc_pipe #(.N(N), .TRUTH(T_MAIN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .start(start), .busy(busy), .out_valid(out_valid),
    .f_out(f_out), .ones_count(ones_count), .done(done)
  );

  func_dc_pipe #(.N(N), .TRUTH(T_ZERO)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_z),
    .x(x), .start(start), .busy(busy_z), .out_valid(out_valid_z),
    .f_out(f_out_z), .ones_count(ones_count_z), .done(done_z)
  );

  func_dc_pipe #(.N(N), .TRUTH(T_ONES)) dut_f (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_f),
    .x(x), .start(start), .busy(busy_f), .out_valid(out_valid_f),
    .f_out(f_out_f), .ones_count(ones_count_f), .done(done_f)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready act=%b exp=0", in_ready);
    end
    tick();
    checks++;
    if ({busy, out_valid, f_out, done, ones_count} !== '0) begin
      errors++;
      $display("FAIL rst_outputs act=%b%b%b%b %0d exp=0",
               busy, out_valid, f_out, done, ones_count);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready act=%b exp=1", in_ready);
    end
    x = 5'd4;
    in_valid = 1'b1;
    repeat (L + 3) tick();
    checks++;
    if (out_valid !== 1'b1 || f_out !== tt[4]) begin
      errors++;
      $display("FAIL pre_rst_stream act=%b/%b exp=1/%b",
               out_valid, f_out, tt[4]);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, out_valid, f_out, done, ones_count, in_ready} !== '0) begin
      errors++;
      $display("FAIL mid_rst_outputs act=%b%b%b%b %0d rdy=%b exp=0",
               busy, out_valid, f_out, done, ones_count, in_ready);
    end
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_ready act=%b exp=1", in_ready);
    end
    for (int k = 0; k < L + 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || f_out !== 1'b0) begin
        errors++;
        $display("FAIL stray_after_rst act=%b/%b exp=0/0", out_valid, f_out);
      end
    end
  endtask

  task automatic test_single();
    int xs[6];
    xs[0] = 4;
    xs[1] = 0;
    xs[2] = 31;
    xs[3] = int'($urandom_range(0, M - 1));
    xs[4] = int'($urandom_range(0, M - 1));
    xs[5] = int'($urandom_range(0, M - 1));
    foreach (xs[n]) begin
      x = N'(xs[n]);
      in_valid = 1'b1;
      for (int k = 1; k <= L + 1; k++) begin
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== (k == L + 1)) begin
          errors++;
          $display("FAIL single_valid x=%0d k=%0d act=%b exp=%b",
                   xs[n], k, out_valid, (k == L + 1));
        end
      end
      checks++;
      if (f_out !== tt[xs[n]]) begin
        errors++;
        $display("FAIL single_f x=%0d act=%b exp=%b", xs[n], f_out, tt[xs[n]]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || f_out !== tt[xs[n]]) begin
        errors++;
        $display("FAIL single_hold x=%0d act=%b/%b exp=0/%b",
                 xs[n], out_valid, f_out, tt[xs[n]]);
      end
    end
  endtask

  task automatic test_stream();
    bit ev [int];
    bit ef [int];
    int nin = 80;
    int xv;
    bit vv;
    for (int i = 0; i < nin + L + 1; i++) begin
      checks++;
      if (out_valid !== ev.exists(cyc)) begin
        errors++;
        $display("FAIL stream_valid i=%0d act=%b exp=%b",
                 i, out_valid, ev.exists(cyc));
      end else if (ev.exists(cyc)) begin
        checks++;
        if (f_out !== ef[cyc]) begin
          errors++;
          $display("FAIL stream_f i=%0d act=%b exp=%b", i, f_out, ef[cyc]);
        end
      end
      if (i < nin) begin
        vv = (i < M) ? 1'b1 : 1'($urandom_range(0, 1));
        xv = (i < M) ? i : int'($urandom_range(0, M - 1));
        in_valid = vv;
        x = N'(xv);
        if (vv) begin
          ev[cyc + L + 1] = 1'b1;
          ef[cyc + L + 1] = tt[xv];
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_sweep(input bit ext, input bit poke);
    int run = 0;
    int dcyc = M + L + 1;
    bit ev, eb, ef;
    start = 1'b1;
    if (ext) begin
      in_valid = 1'b1;
      x = 5'd4;
    end
    for (int i = 1; i <= dcyc + 4; i++) begin
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      eb = (i <= M + L);
      ev = (ext && i == L + 1) || (i >= L + 2 && i <= dcyc);
      ef = 1'b0;
      if (ext && i == L + 1) ef = tt[4];
      if (i >= L + 2 && i <= dcyc) begin
        ef = tt[i - L - 2];
        run += int'(tt[i - L - 2]);
      end
      checks++;
      if (busy !== eb || in_ready !== !eb) begin
        errors++;
        $display("FAIL sweep_busy i=%0d act=%b/%b exp=%b/%b",
                 i, busy, in_ready, eb, !eb);
      end
      checks++;
      if (out_valid !== ev) begin
        errors++;
        $display("FAIL sweep_valid i=%0d act=%b exp=%b", i, out_valid, ev);
      end else if (ev) begin
        checks++;
        if (f_out !== ef) begin
          errors++;
          $display("FAIL sweep_f i=%0d act=%b exp=%b", i, f_out, ef);
        end
      end
      checks++;
      if (done !== (i == dcyc)) begin
        errors++;
        $display("FAIL sweep_done i=%0d act=%b exp=%b", i, done, (i == dcyc));
      end
      checks++;
      if (int'(ones_count) != run) begin
        errors++;
        $display("FAIL sweep_count i=%0d act=%0d exp=%0d", i, ones_count, run);
      end
      if (i == dcyc) begin
        checks++;
        if (done_z !== 1'b1 || int'(ones_count_z) != 0) begin
          errors++;
          $display("FAIL sweep_zero act=%b/%0d exp=1/0", done_z, ones_count_z);
        end
        checks++;
        if (done_f !== 1'b1 || int'(ones_count_f) != M) begin
          errors++;
          $display("FAIL sweep_ones act=%b/%0d exp=1/%0d",
                   done_f, ones_count_f, M);
        end
      end
      if (poke && (i == 10 || i == M + L - 1)) begin
        start = 1'b1;
        in_valid = 1'b1;
        x = N'($urandom_range(0, M - 1));
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int part = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    for (int j = 0; j <= 20 - L - 2; j++) part += int'(tt[j]);
    checks++;
    if (int'(ones_count) != part || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_sweep act=%0d/%b exp=%0d/1", ones_count, busy, part);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || int'(ones_count) != 0) begin
      errors++;
      $display("FAIL rst_sweep act=%b/%b/%0d exp=0/1/0",
               busy, in_ready, ones_count);
    end
    for (int k = 0; k < M; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b0 || int'(ones_count) != 0) begin
        errors++;
        $display("FAIL rst_sweep_quiet k=%0d act=%b/%b/%0d exp=0/0/0",
                 k, out_valid, done, ones_count);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    tt = T_MAIN;
    test_reset();
    test_single();
    test_stream();
    test_sweep(1'b0, 1'b0);
    test_sweep(1'b1, 1'b1);
    test_reset_mid_sweep();
    test_sweep(1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
